// File: rtl/imm_gen_pkg.sv
// Shared constants for the RV32/RV64 immediate generator: format codes,
// base opcodes and the number of per-format statistics counters.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_ILL = 3'd6
    } fmt_e;

    localparam int NUM_CNT = 7;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;

endpackage

// File: rtl/imm_gen_if.sv
// Valid/ready bundle for the immediate generator: instruction in, decoded
// immediate/format out. master drives instructions, slave is the block.
interface imm_gen_if
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    fmt_e            out_fmt;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal
    );
endinterface

// File: rtl/imm_gen_decode.sv
// Combinational opcode classifier and immediate extractor; the immediate is
// assembled as 32 bits and then sign-extended from instr[31] to XLEN.
module imm_gen_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output fmt_e            fmt,
    output logic            illegal
);

    logic [31:0] imm32;
    logic        s;

    assign s = instr[31];

    always_comb begin
        fmt   = FMT_ILL;
        imm32 = '0;
        unique case (instr[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM32, OPC_JALR, OPC_SYSTEM: begin
                fmt   = FMT_I;
                imm32 = {{20{s}}, instr[31:20]};
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{s}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{s}}, s, instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{s}}, s, instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP, OPC_OP32: begin
                fmt   = FMT_R;
                imm32 = '0;
            end
            default: begin
                fmt   = FMT_ILL;
                imm32 = '0;
            end
        endcase
    end

    assign imm     = XLEN'($signed(imm32));
    assign illegal = (fmt == FMT_ILL);

endmodule

// File: rtl/imm_gen_pipe.sv
// One-stage registered immediate generator with valid/ready handshake.
// Define IMM_GEN_STATS_EN to add saturating per-format acceptance counters.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
`ifdef IMM_GEN_STATS_EN
    input  logic             stat_clear,
    input  logic [2:0]       stat_sel,
    output logic [CNT_W-1:0] stat_count,
`endif
    imm_gen_if.slave         bus
);

    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("imm_gen_pipe: CNT_W must be at least 1");
    end

    logic            valid_q, valid_d;
    logic [XLEN-1:0] imm_q, imm_d;
    fmt_e            fmt_q, fmt_d;
    logic            ill_q, ill_d;

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_ill;
    logic            in_ready;
    logic            accept;

    imm_gen_decode #(.XLEN(XLEN)) u_decode (
        .instr   (bus.in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_ill)
    );

    // The single output register is free when empty or draining this cycle.
    assign in_ready = !valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        valid_d = valid_q;
        imm_d   = imm_q;
        fmt_d   = fmt_q;
        ill_d   = ill_q;
        if (accept) begin
            valid_d = 1'b1;
            imm_d   = dec_imm;
            fmt_d   = dec_fmt;
            ill_d   = dec_ill;
        end else if (bus.out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            imm_q   <= '0;
            fmt_q   <= FMT_R;
            ill_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            imm_q   <= imm_d;
            fmt_q   <= fmt_d;
            ill_q   <= ill_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = valid_q;
    assign bus.out_imm     = imm_q;
    assign bus.out_fmt     = fmt_q;
    assign bus.out_illegal = ill_q;

`ifdef IMM_GEN_STATS_EN
    logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Clear wins over a same-cycle increment; counters stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (stat_clear) begin
            cnt_d = '0;
        end else if (accept) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                if (dec_fmt == fmt_e'(i) && cnt_q[i] != '1) begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        stat_count = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            if (stat_sel == 3'(i)) begin
                stat_count = cnt_q[i];
            end
        end
    end
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: a 64-bit instance and a 32-bit instance
// (CNT_W=2) sharing clock and reset; stats checks only with IMM_GEN_STATS_EN.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    imm_gen_if #(.XLEN(64)) if64 ();
    imm_gen_if #(.XLEN(32)) if32 ();

`ifdef IMM_GEN_STATS_EN
    logic        stat_clear64, stat_clear32;
    logic [2:0]  stat_sel64, stat_sel32;
    logic [15:0] stat_count64;
    logic [1:0]  stat_count32;
`endif

    imm_gen_pipe #(.XLEN(64), .CNT_W(16)) u_dut64 (
        .clk        (clk),
        .reset      (reset),
`ifdef IMM_GEN_STATS_EN
        .stat_clear (stat_clear64),
        .stat_sel   (stat_sel64),
        .stat_count (stat_count64),
`endif
        .bus        (if64.slave)
    );

    imm_gen_pipe #(.XLEN(32), .CNT_W(2)) u_dut32 (
        .clk        (clk),
        .reset      (reset),
`ifdef IMM_GEN_STATS_EN
        .stat_clear (stat_clear32),
        .stat_sel   (stat_sel32),
        .stat_count (stat_count32),
`endif
        .bus        (if32.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if64.in_valid = 1'b1; if64.in_instr = 32'hFFC12083; if64.out_ready = 1'b0;
        if32.in_valid = 1'b1; if32.in_instr = 32'h123450B7; if32.out_ready = 1'b0;
        step();
        step();
        n_tests++; if (if64.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid64 got %b want 0", if64.out_valid); end
        n_tests++; if (if64.out_imm !== 64'd0) begin n_fail++; $display("FAIL rst_imm64 got %h want 0", if64.out_imm); end
        n_tests++; if (if64.out_fmt !== FMT_R) begin n_fail++; $display("FAIL rst_fmt64 got %0d want 0", if64.out_fmt); end
        n_tests++; if (if64.out_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_ill64 got %b want 0", if64.out_illegal); end
        n_tests++; if (if32.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid32 got %b want 0", if32.out_valid); end
`ifdef IMM_GEN_STATS_EN
        stat_sel64 = 3'd1; #1;
        n_tests++; if (stat_count64 !== 16'd0) begin n_fail++; $display("FAIL rst_stat got %0d want 0", stat_count64); end
`endif
        reset = 1'b0;
        if64.in_valid = 1'b0;
        if32.in_valid = 1'b0;
        #1;
        n_tests++; if (if64.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", if64.in_ready); end
    endtask

    task automatic test_lw();
        if64.out_ready = 1'b1;
        if64.in_valid  = 1'b1;
        if64.in_instr  = 32'hFFC12083;
        step();
        if64.in_valid = 1'b0;
        n_tests++; if (if64.out_valid !== 1'b1) begin n_fail++; $display("FAIL lw_valid got %b want 1", if64.out_valid); end
        n_tests++; if (if64.out_imm !== 64'hFFFFFFFFFFFFFFFC) begin n_fail++; $display("FAIL lw_imm got %h want fffffffffffffffc", if64.out_imm); end
        n_tests++; if (if64.out_fmt !== FMT_I) begin n_fail++; $display("FAIL lw_fmt got %0d want 1", if64.out_fmt); end
        n_tests++; if (if64.out_illegal !== 1'b0) begin n_fail++; $display("FAIL lw_ill got %b want 0", if64.out_illegal); end
        step();
        n_tests++; if (if64.out_valid !== 1'b0) begin n_fail++; $display("FAIL lw_drain got %b want 0", if64.out_valid); end
    endtask

    task automatic test_decode();
        logic [31:0] vi   [9] = '{32'h7FF00093, 32'h800000B7, 32'hFFDFF06F,
                                  32'h002081B3, 32'h0000003B, 32'hFFF0001B,
                                  32'h0000007F, 32'h00001017, 32'h80008067};
        logic [63:0] vimm [9] = '{64'h00000000000007FF, 64'hFFFFFFFF80000000, 64'hFFFFFFFFFFFFFFFC,
                                  64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF,
                                  64'h0, 64'h0000000000001000, 64'hFFFFFFFFFFFFF800};
        logic [2:0]  vf   [9] = '{3'd1, 3'd4, 3'd5, 3'd0, 3'd0, 3'd1, 3'd6, 3'd4, 3'd1};
        if64.out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if64.in_valid = 1'b1;
            if64.in_instr = vi[i];
            step();
            n_tests++; if (if64.out_valid !== 1'b1) begin n_fail++; $display("FAIL dec%0d_valid got %b want 1", i, if64.out_valid); end
            n_tests++; if (if64.out_imm !== vimm[i]) begin n_fail++; $display("FAIL dec%0d_imm got %h want %h", i, if64.out_imm, vimm[i]); end
            n_tests++; if (if64.out_fmt !== vf[i]) begin n_fail++; $display("FAIL dec%0d_fmt got %0d want %0d", i, if64.out_fmt, vf[i]); end
            n_tests++; if (if64.out_illegal !== (vf[i] == 3'd6)) begin n_fail++; $display("FAIL dec%0d_ill got %b want %b", i, if64.out_illegal, vf[i] == 3'd6); end
        end
        if64.in_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        if64.out_ready = 1'b1;
        if64.in_valid  = 1'b1;
        if64.in_instr  = 32'h00512423;
        step();
        n_tests++; if (if64.out_imm !== 64'd8 || if64.out_fmt !== FMT_S || if64.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_sw got v=%b imm=%h fmt=%0d want v=1 imm=8 fmt=2", if64.out_valid, if64.out_imm, if64.out_fmt); end
        n_tests++; if (if64.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", if64.in_ready); end
        if64.in_instr = 32'hFE000EE3;
        step();
        if64.in_valid = 1'b0;
        n_tests++; if (if64.out_imm !== 64'hFFFFFFFFFFFFFFFC || if64.out_fmt !== FMT_B || if64.out_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_beq got v=%b imm=%h fmt=%0d want v=1 imm=fffffffffffffffc fmt=3", if64.out_valid, if64.out_imm, if64.out_fmt); end
        step();
        n_tests++; if (if64.out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b want 0", if64.out_valid); end
    endtask

    task automatic test_xlen32();
        if32.out_ready = 1'b1;
        if32.in_valid  = 1'b1;
        if32.in_instr  = 32'h123450B7;
        step();
        n_tests++; if (if32.out_imm !== 32'h12345000 || if32.out_fmt !== FMT_U) begin
            n_fail++; $display("FAIL x32_lui got imm=%h fmt=%0d want imm=12345000 fmt=4", if32.out_imm, if32.out_fmt); end
        if32.in_instr = 32'h0000007F;
        step();
        if32.in_valid = 1'b0;
        n_tests++; if (if32.out_imm !== 32'd0 || if32.out_fmt !== FMT_ILL || if32.out_illegal !== 1'b1) begin
            n_fail++; $display("FAIL x32_ill got imm=%h fmt=%0d ill=%b want imm=0 fmt=6 ill=1", if32.out_imm, if32.out_fmt, if32.out_illegal); end
        step();
    endtask

    task automatic test_backpressure();
        if64.out_ready = 1'b0;
        if64.in_valid  = 1'b1;
        if64.in_instr  = 32'h7FF00093;
        step();
        if64.in_instr = 32'hFFC12083;
        #1;
        n_tests++; if (if64.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %b want 0", if64.in_ready); end
        for (int k = 0; k < 2; k++) begin
            step();
            n_tests++; if (if64.out_valid !== 1'b1 || if64.out_imm !== 64'h7FF || if64.out_fmt !== FMT_I) begin
                n_fail++; $display("FAIL bp_hold%0d got v=%b imm=%h fmt=%0d want v=1 imm=7ff fmt=1", k, if64.out_valid, if64.out_imm, if64.out_fmt); end
        end
        if64.out_ready = 1'b1;
        #1;
        n_tests++; if (if64.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release got %b want 1", if64.in_ready); end
        step();
        if64.in_valid = 1'b0;
        n_tests++; if (if64.out_valid !== 1'b1 || if64.out_imm !== 64'hFFFFFFFFFFFFFFFC) begin
            n_fail++; $display("FAIL bp_second got v=%b imm=%h want v=1 imm=fffffffffffffffc", if64.out_valid, if64.out_imm); end
        step();
        n_tests++; if (if64.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain got %b want 0", if64.out_valid); end
    endtask

    task automatic test_reset_stall();
        if64.out_ready = 1'b0;
        if64.in_valid  = 1'b1;
        if64.in_instr  = 32'h7FF00093;
        step();
        n_tests++; if (if64.out_valid !== 1'b1) begin n_fail++; $display("FAIL rs_held got %b want 1", if64.out_valid); end
        reset          = 1'b1;
        if64.out_ready = 1'b1;
        if64.in_instr  = 32'hFFC12083;
        step();
        n_tests++; if (if64.out_valid !== 1'b0 || if64.out_imm !== 64'd0) begin
            n_fail++; $display("FAIL rs_flush got v=%b imm=%h want v=0 imm=0", if64.out_valid, if64.out_imm); end
        reset         = 1'b0;
        if64.in_valid = 1'b0;
        step();
        n_tests++; if (if64.out_valid !== 1'b0) begin n_fail++; $display("FAIL rs_after got %b want 0", if64.out_valid); end
    endtask

`ifdef IMM_GEN_STATS_EN
    task automatic test_stats();
        reset = 1'b1;
        step();
        reset = 1'b0;
        if64.out_ready = 1'b1;
        if64.in_valid  = 1'b1;
        if64.in_instr  = 32'hFFC12083;
        step(); step(); step();
        if64.in_instr = 32'h00512423;
        step();
        if64.in_valid = 1'b0;
        stat_sel64 = 3'd1; #1;
        n_tests++; if (stat_count64 !== 16'd3) begin n_fail++; $display("FAIL st_loads got %0d want 3", stat_count64); end
        stat_sel64 = 3'd2; #1;
        n_tests++; if (stat_count64 !== 16'd1) begin n_fail++; $display("FAIL st_stores got %0d want 1", stat_count64); end
        stat_sel64 = 3'd7; #1;
        n_tests++; if (stat_count64 !== 16'd0) begin n_fail++; $display("FAIL st_sel7 got %0d want 0", stat_count64); end
        step();
        if64.in_valid = 1'b1;
        if64.in_instr = 32'hFFC12083;
        stat_clear64  = 1'b1;
        step();
        if64.in_valid = 1'b0;
        stat_clear64  = 1'b0;
        stat_sel64    = 3'd1; #1;
        n_tests++; if (stat_count64 !== 16'd0) begin n_fail++; $display("FAIL st_clear got %0d want 0", stat_count64); end
        if32.out_ready = 1'b1;
        if32.in_valid  = 1'b1;
        if32.in_instr  = 32'hFFC12083;
        for (int k = 0; k < 5; k++) step();
        if32.in_valid = 1'b0;
        stat_sel32 = 3'd1; #1;
        n_tests++; if (stat_count32 !== 2'd3) begin n_fail++; $display("FAIL st_sat got %0d want 3", stat_count32); end
        step();
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        if64.in_valid = 1'b0; if64.in_instr = '0; if64.out_ready = 1'b0;
        if32.in_valid = 1'b0; if32.in_instr = '0; if32.out_ready = 1'b0;
`ifdef IMM_GEN_STATS_EN
        stat_clear64 = 1'b0; stat_sel64 = 3'd0;
        stat_clear32 = 1'b0; stat_sel32 = 3'd0;
`endif
        test_reset();
        test_lw();
        test_decode();
        test_back_to_back();
        test_xlen32();
        test_backpressure();
        test_reset_stall();
`ifdef IMM_GEN_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 64, immediate width; legal values 32 and 64.
REQ-002 Parameter CNT_W, default 16, width of each statistics counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 in_valid  in  1  in_instr is valid.
REQ-006 in_ready  out  1  block accepts in_instr this cycle.
REQ-007 in_instr  in  32  RV32/RV64 base instruction word.
REQ-008 out_valid  out  1  out_imm, out_fmt and out_illegal are valid.
REQ-009 out_ready  in  1  consumer accepts the output this cycle.
REQ-010 out_imm  out  XLEN  sign-extended immediate.
REQ-011 out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=6.
REQ-012 out_illegal  out  1  opcode not recognised.
REQ-013 stat_clear  in  1  clears all counters (only with IMM_GEN_STATS_EN).
REQ-014 stat_sel  in  3  selects a counter by format code (only with IMM_GEN_STATS_EN).
REQ-015 stat_count  out  CNT_W  value of the selected counter (only with IMM_GEN_STATS_EN).

Function
REQ-016 Transfer on an interface SHALL occur only when valid and ready are both 1 in the same cycle.
REQ-017 in_ready SHALL equal (!out_valid || out_ready), combinationally.
REQ-018 An accepted instruction SHALL appear on the outputs with out_valid=1 on the next cycle; latency is 1 cycle and throughput is 1 per cycle.
REQ-019 While out_valid=1 and out_ready=0, out_imm, out_fmt and out_illegal SHALL hold stable.
REQ-020 If the output transfers and no input is accepted in the same cycle, out_valid SHALL go to 0.
REQ-021 If the output transfers and an input is accepted in the same cycle, out_valid SHALL stay 1 and the outputs SHALL load the new result.
REQ-022 Opcode decode:
- 0000011, 0010011, 0011011, 1100111, 1110011 map to I.
- 0100011 maps to S.
- 1100011 maps to B.
- 0110111 and 0010111 map to U.
- 1101111 maps to J.
- 0110011 and 0111011 map to R.
- Any other opcode maps to ILL.
REQ-023 Immediate bit fields:
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-024 Every immediate SHALL be sign-extended from instr[31] to XLEN.
REQ-025 For R and ILL, out_imm SHALL be 0.
REQ-026 out_illegal SHALL be 1 exactly when out_fmt=ILL.
REQ-027 No output SHALL change when in_valid=1 and in_ready=0; the instruction is not consumed.

Reset
REQ-028 While reset=1, the following SHALL be forced to 0 on each clock edge: out_valid, out_imm, out_fmt, out_illegal and all counters.
REQ-029 Reset SHALL override any handshake in the same cycle.
REQ-030 A held (stalled) output SHALL be discarded by reset, not delivered.
REQ-031 in_ready SHALL be 1 in the first cycle after reset deasserts.

Configuration
REQ-032 With macro IMM_GEN_STATS_EN defined:
- Seven CNT_W counters exist, one per format code 0..6.
- A counter increments when an instruction of that format is accepted at the input.
- Counters saturate at all-ones.
- stat_count = counter[stat_sel]; stat_sel=7 reads 0.
REQ-033 stat_clear=1 SHALL zero all counters on the next edge; it takes priority over a simultaneous increment, which is then not counted.
REQ-034 Without IMM_GEN_STATS_EN:
- stat_clear, stat_sel and stat_count SHALL be absent.
- No counter logic SHALL be synthesised.
- Datapath behaviour is unchanged.

Structure
REQ-035 Shared package imm_gen_pkg SHALL hold the format-code constants, the opcode constants and the counter-count constant (7).
REQ-036 Decode and extension SHALL live in a combinational sub-module imm_gen_decode (in_instr -> imm, fmt, illegal), instantiated once ahead of the output register.

Verification
REQ-037 in_instr=0xFFC12083 (lw x1,-4(x2)), XLEN=64 -> one cycle later out_imm=0xFFFFFFFFFFFFFFFC, out_fmt=1, out_illegal=0.
REQ-038 Back-to-back inputs 0x00512423 (sw) then 0xFE000EE3 (beq -4) with out_ready=1 -> consecutive outputs:
- First: imm=8, fmt=2.
- Second: imm=0xFFFFFFFFFFFFFFFC, fmt=3.
REQ-039 in_instr=0x123450B7 (lui) with XLEN=32 -> out_imm=0x12345000, fmt=4; in_instr=0x0000007F -> imm=0, fmt=6, out_illegal=1.
REQ-040 Backpressure: out_ready=0 and two inputs offered -> first result held stable, in_ready=0, second not accepted; out_ready=1 -> first delivered, second accepted that cycle and delivered next.
REQ-041 Reset while a stalled output is held -> out_valid=0 next cycle; the held result is never delivered.
REQ-042 Stats on: 3 loads accepted, stat_sel=1 -> stat_count=3; stat_clear together with a 4th load -> stat_count=0; CNT_W=2 with 5 loads -> stat_count=3.
